// File: rtl/lfsr16_prbs_checker.sv
// lfsr16_prbs_checker: receive-side BER checker for the 16-bit
// Fibonacci LFSR stream (taps 16,14,13,11); syncs, flywheels, counts errors.
module lfsr16_prbs_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [15:0]          data,
  output logic                 locked,
  output logic [1:0]           state,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 zero_det
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int RUN_MAX =
    (LOCK_COUNT > UNLOCK_COUNT) ?
    LOCK_COUNT : UNLOCK_COUNT;
  localparam int RUN_W = $clog2(RUN_MAX + 1);

  localparam logic [RUN_W-1:0] LOCK_TGT =
    RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] UNLOCK_TGT =
    RUN_W'(UNLOCK_COUNT);

  function automatic logic [15:0] nxt(
    input logic [15:0] w
  );
    nxt = {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
  endfunction

  logic [1:0]           state_q, state_d;
  logic [15:0]          exp_q, exp_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_flag_q, err_flag_d;
  logic                 zero_q, zero_d;
  logic                 locked_q, locked_d;

  logic                 in_sync;
  logic                 in_locked;
  logic                 is_zero;
  logic                 is_match;
  logic [RUN_W-1:0]     run_inc;
  logic [ERR_CNT_W-1:0] err_inc;
  logic                 err_sat;

  // Per-word decode terms shared by every state.
  always_comb begin
    in_sync   = (state_q == ST_SYNC);
    in_locked = (state_q == ST_LOCKED);
    is_zero   = (data == 16'h0000);
    is_match  = (data == exp_q);
    run_inc   = run_q + 1'b1;
    err_sat   = &err_cnt_q;
    err_inc   = err_sat ? err_cnt_q
                        : err_cnt_q + 1'b1;
  end

  // Sync FSM, flywheel prediction and error accounting.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    run_d      = run_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = 1'b0;
    zero_d     = 1'b0;
    if (valid) begin
      zero_d = is_zero;
      unique case (1'b1)
        in_locked: begin
          exp_d = nxt(exp_q);
          if (is_match) begin
            run_d = '0;
          end else begin
            err_flag_d = 1'b1;
            err_cnt_d  = err_inc;
            run_d      = run_inc;
            if (run_inc == UNLOCK_TGT) begin
              state_d = ST_SEARCH;
              run_d   = '0;
            end
          end
        end
        in_sync: begin
          if (is_match) begin
            exp_d = nxt(data);
            run_d = run_inc;
            if (run_inc == LOCK_TGT) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end
          end else if (!is_zero) begin
            exp_d = nxt(data);
            run_d = '0;
          end else begin
            state_d = ST_SEARCH;
            run_d   = '0;
          end
        end
        default: begin
          // Encoding 3 is unused and behaves as SEARCH.
          if (!is_zero) begin
            exp_d   = nxt(data);
            run_d   = '0;
            state_d = ST_SYNC;
          end else begin
            state_d = ST_SEARCH;
          end
        end
      endcase
    end
    // Clear beats a same-edge error; err_flag still pulses.
    if (clear) begin
      err_cnt_d = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_SEARCH;
      exp_q      <= '0;
      run_q      <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      zero_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      run_q      <= run_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      zero_q     <= zero_d;
      locked_q   <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign state     = state_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_cnt_q;
  assign zero_det  = zero_q;

endmodule
